// File: rtl/sub_pkg.sv
// sub_pkg -- shared definitions for the bit-serial subtractor.
//
// Contents:
//   IDLE / RUN / DONE  FSM state encodings (2-bit constants)
//   DEFAULT_WIDTH      default operand width
//   clog2()            ceiling log2, used to size the bit counter
package sub_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 4;

    // Smallest r such that 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell -- one-bit combinational full subtractor.
//
// Ports:
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bin  in   borrow in
//   d    out  difference bit  (a - b - bin, modulo 2)
//   bout out  borrow out      (1 when a < b + bin)
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // A borrow leaves this bit when b beats a outright, or when a and b
    // are equal and an incoming borrow has to propagate through.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor -- bit-serial subtractor, Diff = A - B - Bin, LSB first.
//
// A single full_subtractor_cell is reused across WIDTH cycles. Operands are
// captured into shift registers on an accepted start, one bit is consumed per
// RUN cycle, and a final RUN cycle publishes the result so that done appears
// WIDTH+1 cycles after the accepting edge.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled in IDLE and DONE only
//   A, B   in   minuend / subtrahend (WIDTH bits)
//   Bin    in   borrow in
//   busy   out  high while a subtraction is in progress
//   done   out  one-cycle completion pulse
//   Diff   out  registered difference (WIDTH bits)
//   Bout   out  registered unsigned borrow out
//   Ovf    out  registered signed overflow (only with SUB_SIGNED_OVF_EN)
//
// Build option: define SUB_SIGNED_OVF_EN to add the Ovf port and the operand
// MSB capture flops that feed it.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
`ifdef SUB_SIGNED_OVF_EN
    output logic             Ovf,
`endif
    output logic             Bout
);

    localparam int CW = (WIDTH > 1) ? clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             cell_d;
    logic             cell_bout;

`ifdef SUB_SIGNED_OVF_EN
    logic am;
    logic bm;
    logic ovf_q;
`endif

    full_subtractor_cell u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Control and datapath share one register block. 'last' marks that the
    // final bit has been consumed; the RUN cycle that sees it set publishes
    // the result instead of shifting, which gives the WIDTH+1 cycle busy window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            last  <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            am    <= 1'b0;
            bm    <= 1'b0;
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        sa    <= A;
                        sb    <= B;
                        br    <= Bin;
                        cnt   <= '0;
                        last  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
                        am    <= A[WIDTH-1];
                        bm    <= B[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (last) begin
                        state <= DONE;
                        Diff  <= res;
                        Bout  <= br;
`ifdef SUB_SIGNED_OVF_EN
                        ovf_q <= (am != bm) && (res[WIDTH-1] != am);
`endif
                    end else begin
                        res <= {cell_d, res[WIDTH-1:1]};
                        sa  <= {1'b0, sa[WIDTH-1:1]};
                        sb  <= {1'b0, sb[WIDTH-1:1]};
                        br  <= cell_bout;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            last <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef SUB_SIGNED_OVF_EN
    assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor -- directed self-checking bench for serial_subtractor
// at WIDTH=4. Inputs are driven and outputs sampled on the falling edge.
// Build with SUB_SIGNED_OVF_EN defined to also check the Ovf port.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Bout;
`ifdef SUB_SIGNED_OVF_EN
    logic         Ovf;
`endif

    int testsRun;
    int failCount;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
`ifdef SUB_SIGNED_OVF_EN
        .Ovf   (Ovf),
`endif
        .Bout  (Bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle with the given operands, then wait (bounded)
    // for done. Returns at the falling edge where done is high.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin, output logic gotDone,
                                 output int busyCycles);
        int cycles;
        @(negedge clk);
        A = a;
        B = b;
        Bin = bin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        busyCycles = 0;
        while (!done && cycles < 20) begin
            if (busy) busyCycles++;
            @(negedge clk);
            cycles++;
        end
        gotDone = done;
    endtask

    function automatic logic [W-1:0] modelDiff(input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic bin);
        return W'(int'(a) - int'(b) - int'(bin));
    endfunction

    function automatic logic modelBout(input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic bin);
        return int'(a) < int'(b) + int'(bin);
    endfunction

    function automatic logic modelOvf(input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic bin);
        logic [W-1:0] d;
        d = modelDiff(a, b, bin);
        return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    endfunction

    initial begin
        logic gotDone;
        int   busyCycles;
        int   cycles;
        int   donePulses;
        logic [W-1:0] seenDiff;
        logic seenBout;

        testsRun = 0;
        failCount = 0;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        Bin = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_diff", 32'(Diff), 32'd0);
        checkOutput("reset_bout", 32'(Bout), 32'd0);
`ifdef SUB_SIGNED_OVF_EN
        checkOutput("reset_ovf", 32'(Ovf), 32'd0);
`endif

        // 9 - 3 = 6, busy for WIDTH+1 cycles, done exactly one cycle
        applyStimulus(4'd9, 4'd3, 1'b0, gotDone, busyCycles);
        checkOutput("op1_done", 32'(gotDone), 32'd1);
        checkOutput("op1_busy_cycles", 32'(busyCycles), 32'd5);
        checkOutput("op1_busy_in_done", 32'(busy), 32'd0);
        checkOutput("op1_diff", 32'(Diff), 32'h6);
        checkOutput("op1_bout", 32'(Bout), 32'd0);
        @(negedge clk);
        checkOutput("op1_done_one_cycle", 32'(done), 32'd0);
        checkOutput("op1_diff_hold", 32'(Diff), 32'h6);

        // 3 - 9 wraps with a borrow
        applyStimulus(4'd3, 4'd9, 1'b0, gotDone, busyCycles);
        checkOutput("op2_done", 32'(gotDone), 32'd1);
        checkOutput("op2_diff", 32'(Diff), 32'hA);
        checkOutput("op2_bout", 32'(Bout), 32'd1);
`ifdef SUB_SIGNED_OVF_EN
        checkOutput("op2_ovf", 32'(Ovf), 32'(modelOvf(4'd3, 4'd9, 1'b0)));
`endif

        // 0 - 0 - 1 with start held high through DONE: back-to-back F - F
        @(negedge clk);
        A = 4'h0;
        B = 4'h0;
        Bin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        A = 4'hF;
        B = 4'hF;
        Bin = 1'b0;
        checkOutput("b2b_busy_first", 32'(busy), 32'd1);
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("b2b_first_done", 32'(done), 32'd1);
        checkOutput("b2b_first_diff", 32'(Diff), 32'hF);
        checkOutput("b2b_first_bout", 32'(Bout), 32'd1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy_second", 32'(busy), 32'd1);
        checkOutput("b2b_done_low", 32'(done), 32'd0);
        checkOutput("b2b_diff_hold_run", 32'(Diff), 32'hF);
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("b2b_second_done", 32'(done), 32'd1);
        checkOutput("b2b_second_diff", 32'(Diff), 32'h0);
        checkOutput("b2b_second_bout", 32'(Bout), 32'd0);

        // 5 - 2 with an extra start pulse while busy that must be ignored
        @(negedge clk);
        A = 4'd5;
        B = 4'd2;
        Bin = 1'b0;
        start = 1'b1;
        donePulses = 0;
        seenDiff = '0;
        seenBout = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 2) begin
                A = 4'd1;
                B = 4'd1;
                start = 1'b1;
            end
            if (done) begin
                donePulses++;
                seenDiff = Diff;
                seenBout = Bout;
            end
        end
        start = 1'b0;
        checkOutput("ignore_done_pulses", 32'(donePulses), 32'd1);
        checkOutput("ignore_diff", 32'(seenDiff), 32'h3);
        checkOutput("ignore_bout", 32'(seenBout), 32'd0);

        // C - 4 aborted by reset two cycles into RUN
        @(negedge clk);
        A = 4'hC;
        B = 4'h4;
        Bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_diff", 32'(Diff), 32'd0);
        checkOutput("abort_bout", 32'(Bout), 32'd0);
        donePulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) donePulses++;
        end
        checkOutput("abort_no_done", 32'(donePulses), 32'd0);
        applyStimulus(4'd7, 4'd7, 1'b0, gotDone, busyCycles);
        checkOutput("after_abort_done", 32'(gotDone), 32'd1);
        checkOutput("after_abort_diff", 32'(Diff), 32'h0);
        checkOutput("after_abort_bout", 32'(Bout), 32'd0);

        // Borrow-in edge cases
        applyStimulus(4'hF, 4'h0, 1'b1, gotDone, busyCycles);
        checkOutput("bin_f0_diff", 32'(Diff), 32'hE);
        checkOutput("bin_f0_bout", 32'(Bout), 32'd0);
        applyStimulus(4'h8, 4'h8, 1'b1, gotDone, busyCycles);
        checkOutput("bin_88_diff", 32'(Diff), 32'hF);
        checkOutput("bin_88_bout", 32'(Bout), 32'd1);

`ifdef SUB_SIGNED_OVF_EN
        // Signed overflow cases
        applyStimulus(4'h8, 4'h1, 1'b0, gotDone, busyCycles);
        checkOutput("ovf_81_diff", 32'(Diff), 32'h7);
        checkOutput("ovf_81_bout", 32'(Bout), 32'd0);
        checkOutput("ovf_81_ovf", 32'(Ovf), 32'd1);
        applyStimulus(4'h7, 4'hF, 1'b0, gotDone, busyCycles);
        checkOutput("ovf_7f_diff", 32'(Diff), 32'h8);
        checkOutput("ovf_7f_bout", 32'(Bout), 32'd1);
        checkOutput("ovf_7f_ovf", 32'(Ovf), 32'd1);
`endif

        // Full 4-bit sweep against the reference model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    applyStimulus(W'(a), W'(b), c[0], gotDone, busyCycles);
                    checkOutput($sformatf("sweep_done_%0d_%0d_%0d", a, b, c),
                                32'(gotDone), 32'd1);
                    checkOutput($sformatf("sweep_diff_%0d_%0d_%0d", a, b, c),
                                32'(Diff), 32'(modelDiff(W'(a), W'(b), c[0])));
                    checkOutput($sformatf("sweep_bout_%0d_%0d_%0d", a, b, c),
                                32'(Bout), 32'(modelBout(W'(a), W'(b), c[0])));
`ifdef SUB_SIGNED_OVF_EN
                    checkOutput($sformatf("sweep_ovf_%0d_%0d_%0d", a, b, c),
                                32'(Ovf), 32'(modelOvf(W'(a), W'(b), c[0])));
`endif
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
